// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order requests to a variable-latency
// instruction memory and buffers returned words in a small queue drained by decode.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned QDEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        br_selE,
   input  logic [31:0] br_targetE,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        instr_validD,
   input  logic        instr_readyD,
   output logic [31:0] instrD,
   output logic [31:0] pcD
);

   localparam int unsigned PW = $clog2(QDEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW:0] QDEPTH_EXT = QDEPTH[CW:0];
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   logic [31:0]   pc_q, pc_d;
   logic [31:0]   r_q, r_d;
   logic [CW-1:0] c_q, c_d;
   logic [CW-1:0] p_q, p_d;
   logic [CW-1:0] x_q, x_d;
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   entry_t        queue_mem [QDEPTH];

   logic        req_fire;
   logic        enq;
   logic        deq;
   logic [31:0] target;
   logic [CW:0] inflight;
   logic        unused_target_bits;

   // Targets are word aligned; the low two bits carry no information.
   assign target             = {br_targetE[31:2], 2'b00};
   assign unused_target_bits = ^br_targetE[1:0];

   // Credit check counts every slot already promised: queued words plus requests in flight.
   assign inflight       = {1'b0, p_q} + {1'b0, c_q};
   assign imem_req_valid = !rst && !br_selE && (inflight < QDEPTH_EXT);
   assign imem_addr      = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign instr_validD = (c_q != '0);
   assign instrD       = instr_validD ? queue_mem[head_q].instr : NOP;
   assign pcD          = instr_validD ? queue_mem[head_q].pc    : 32'h0000_0000;

   always_comb begin
      // NOTE: every variable gets a default first so no path through the block infers a latch.
      pc_d   = pc_q;
      r_d    = r_q;
      c_d    = c_q;
      p_d    = p_q;
      x_d    = x_q;
      head_d = head_q;
      tail_d = tail_q;
      enq    = 1'b0;
      deq    = 1'b0;

      if (br_selE) begin
         pc_d   = target;
         r_d    = target;
         c_d    = '0;
         head_d = '0;
         tail_d = '0;
         p_d    = p_q - CW'(imem_rsp_valid);
         x_d    = p_d;
      end else begin
         if (req_fire) begin
            pc_d = pc_q + 32'd4;
         end
         p_d = p_q + CW'(req_fire) - CW'(imem_rsp_valid);

         // Responses that belong to a redirected-away path are counted off before enqueueing.
         if (imem_rsp_valid) begin
            if (x_q != '0) begin
               x_d = x_q - CW'(1);
            end else begin
               enq    = 1'b1;
               r_d    = r_q + 32'd4;
               tail_d = tail_q + PW'(1);
            end
         end

         deq = instr_validD && instr_readyD;
         if (deq) begin
            head_d = head_q + PW'(1);
         end
         c_d = c_q + CW'(enq) - CW'(deq);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q   <= RESET_PC;
         r_q    <= RESET_PC;
         c_q    <= '0;
         p_q    <= '0;
         x_q    <= '0;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         pc_q   <= pc_d;
         r_q    <= r_d;
         c_q    <= c_d;
         p_q    <= p_d;
         x_q    <= x_d;
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

   // NOTE: the queue storage is not reset; an entry is only visible once the count covers it.
   always_ff @(posedge clk) begin
      if (enq && !rst) begin
         queue_mem[tail_q] <= '{pc: r_q, instr: imem_rsp_data};
      end
   end

endmodule
